// File: rtl/game_pkg.sv
// Shared mode encoding and default timing/score constants for the game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    START     = 3'd0,
    GAME      = 3'd1,
    PAUSE     = 3'd2,
    WIN       = 3'd3,
    GAME_OVER = 3'd4
  } game_mode_t;

  localparam int GAME_WIN_SCORE     = 5;
  localparam int GAME_ROUND_CYCLES  = 1000000;
  localparam int GAME_RESULT_CYCLES = 500000;

endpackage

// File: rtl/score_bank.sv
// Per-player saturating score counters with combinational win/argmax lookahead
// computed on the next-score values, so the FSM decides on this cycle's events.
module score_bank #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 5,
  parameter int IDX_W       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clr,
  input  logic                           i_en,
  input  logic [NUM_PLAYERS-1:0]         i_evt,
  output logic [NUM_PLAYERS*SCORE_W-1:0] o_scores,
  output logic                           o_any_reached,
  output logic [IDX_W-1:0]               o_first_idx,
  output logic [IDX_W-1:0]               o_max_idx,
  output logic                           o_max_tie
);

  localparam logic [SCORE_W-1:0] SAT_V = '1;
  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);

  logic [SCORE_W-1:0]     r_score [NUM_PLAYERS];
  logic [SCORE_W-1:0]     w_next  [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_reached;
  logic [SCORE_W-1:0]     w_max;

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_next[i]    = (i_evt[i] && r_score[i] != SAT_V) ? r_score[i] + SCORE_W'(1) : r_score[i];
      w_reached[i] = (w_next[i] >= WIN_V);
      o_scores[i*SCORE_W +: SCORE_W] = r_score[i];
    end
  end

  // Descending scan leaves the lowest reaching index in place.
  always_comb begin
    o_first_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (w_reached[i]) o_first_idx = IDX_W'(i);
    end
  end

  assign o_any_reached = |w_reached;

  always_comb begin
    w_max     = w_next[0];
    o_max_idx = '0;
    o_max_tie = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (w_next[i] > w_max) begin
        w_max     = w_next[i];
        o_max_idx = IDX_W'(i);
        o_max_tie = 1'b0;
      end else if (w_next[i] == w_max) begin
        o_max_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
    end else if (i_en) begin
      for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= w_next[i];
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// N-player game-mode sequencer: button edge detect, mode FSM, round timer and
// timed result screen. Scores live in score_bank.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int  NUM_PLAYERS   = 2,
  parameter int  SCORE_W       = 4,
  parameter int  WIN_SCORE     = GAME_WIN_SCORE,
  parameter int  ROUND_CYCLES  = GAME_ROUND_CYCLES,
  parameter int  RESULT_CYCLES = GAME_RESULT_CYCLES,
  localparam int IDX_W         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int RL_W          = (ROUND_CYCLES > 0) ? $clog2(ROUND_CYCLES + 1) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_btn,
  input  logic                           pause_btn,
  input  logic [NUM_PLAYERS-1:0]         score_evt,
  output game_mode_t                     mode,
  output logic [IDX_W-1:0]               winner,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [RL_W-1:0]                round_left,
  output logic                           mode_change
);

  localparam int RES_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [RL_W-1:0]  RL_LOAD  = RL_W'(ROUND_CYCLES);
  localparam logic [RES_W-1:0] RES_LOAD = RES_W'(RESULT_CYCLES - 1);

  game_mode_t       r_mode, w_mode_nxt;
  logic             r_start_q, r_pause_q, r_mode_change;
  logic             w_start_rise, w_pause_rise;
  logic [RL_W-1:0]  r_rl, w_rl_nxt;
  logic [RES_W-1:0] r_res, w_res_nxt;
  logic [IDX_W-1:0] r_winner, w_winner_nxt;
  logic             w_clr, w_en;
  logic             w_any_reached, w_max_tie;
  logic [IDX_W-1:0] w_first_idx, w_max_idx;

  assign w_start_rise = start_btn & ~r_start_q;
  assign w_pause_rise = pause_btn & ~r_pause_q;

  score_bank #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .SCORE_W     (SCORE_W),
    .WIN_SCORE   (WIN_SCORE),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_clr),
    .i_en          (w_en),
    .i_evt         (score_evt),
    .o_scores      (scores),
    .o_any_reached (w_any_reached),
    .o_first_idx   (w_first_idx),
    .o_max_idx     (w_max_idx),
    .o_max_tie     (w_max_tie)
  );

  always_comb begin
    w_mode_nxt   = r_mode;
    w_rl_nxt     = r_rl;
    w_res_nxt    = r_res;
    w_winner_nxt = r_winner;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    case (r_mode)
      START: begin
        if (w_start_rise) begin
          w_mode_nxt   = GAME;
          w_clr        = 1'b1;
          w_rl_nxt     = RL_LOAD;
          w_winner_nxt = '0;
        end
      end
      GAME: begin
        w_en = 1'b1;
        if (ROUND_CYCLES > 0 && r_rl != '0) w_rl_nxt = r_rl - RL_W'(1);
        // Win beats timeout, timeout beats pause.
        if (w_any_reached) begin
          w_mode_nxt   = WIN;
          w_winner_nxt = w_first_idx;
          w_res_nxt    = RES_LOAD;
        end else if (ROUND_CYCLES > 0 && r_rl == RL_W'(1)) begin
          w_res_nxt = RES_LOAD;
          if (w_max_tie) begin
            w_mode_nxt = GAME_OVER;
          end else begin
            w_mode_nxt   = WIN;
            w_winner_nxt = w_max_idx;
          end
        end else if (w_pause_rise) begin
          w_mode_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (w_start_rise) begin
          w_mode_nxt = START;
          w_clr      = 1'b1;
        end else if (w_pause_rise) begin
          w_mode_nxt = GAME;
        end
      end
      WIN, GAME_OVER: begin
        if (w_start_rise) begin
          w_mode_nxt   = GAME;
          w_clr        = 1'b1;
          w_rl_nxt     = RL_LOAD;
          w_winner_nxt = '0;
        end else if (r_res == '0) begin
          w_mode_nxt = START;
        end else begin
          w_res_nxt = r_res - RES_W'(1);
        end
      end
      default: w_mode_nxt = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode        <= START;
      r_rl          <= RL_LOAD;
      r_res         <= '0;
      r_winner      <= '0;
      r_mode_change <= 1'b0;
      r_start_q     <= 1'b0;
      r_pause_q     <= 1'b0;
    end else begin
      r_mode        <= w_mode_nxt;
      r_rl          <= w_rl_nxt;
      r_res         <= w_res_nxt;
      r_winner      <= w_winner_nxt;
      r_mode_change <= (w_mode_nxt != r_mode);
      r_start_q     <= start_btn;
      r_pause_q     <= pause_btn;
    end
  end

  assign mode        = r_mode;
  assign winner      = r_winner;
  assign round_left  = r_rl;
  assign mode_change = r_mode_change;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two configurations (2 and 4 players) against a
// behavioural reference model, plus directed scenarios with literal expectations.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [1:0] evt0 = '0;
  logic [3:0] evt1 = '0;

  game_mode_t mode0, mode1;
  logic [0:0]  winner0;
  logic [1:0]  winner1;
  logic [7:0]  scores0;
  logic [15:0] scores1;
  logic [4:0]  rl0;
  logic [5:0]  rl1;
  logic        mc0, mc1;

  int total = 0;
  int bad   = 0;

  game_flow_ctrl #(.NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(3), .ROUND_CYCLES(20),
                   .RESULT_CYCLES(8)) dut0 (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn), .score_evt(evt0),
    .mode(mode0), .winner(winner0), .scores(scores0), .round_left(rl0), .mode_change(mc0));

  game_flow_ctrl #(.NUM_PLAYERS(4), .SCORE_W(4), .WIN_SCORE(15), .ROUND_CYCLES(60),
                   .RESULT_CYCLES(5)) dut1 (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn), .score_evt(evt1),
    .mode(mode1), .winner(winner1), .scores(scores1), .round_left(rl1), .mode_change(mc1));

  always #5 clk = ~clk;

  // Reference model state, index 0/1 per DUT instance.
  game_mode_t m_mode [2];
  int m_s   [2][8];
  int m_win [2];
  int m_rl  [2];
  int m_res [2];
  bit m_mc  [2];
  bit m_sq  [2];
  bit m_pq  [2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int id, input int np, input int ws, input int rc,
                            input int rs, input bit r, input bit sb, input bit pb,
                            input logic [7:0] ev);
    game_mode_t old;
    bit sr, pr;
    int nx [8];
    int first, best, nbest, bidx, old_rl;
    if (r) begin
      m_mode[id] = START; m_win[id] = 0; m_rl[id] = rc; m_res[id] = 0;
      m_mc[id] = 0; m_sq[id] = 0; m_pq[id] = 0;
      for (int i = 0; i < 8; i++) m_s[id][i] = 0;
      return;
    end
    sr = sb && !m_sq[id];
    pr = pb && !m_pq[id];
    m_sq[id] = sb;
    m_pq[id] = pb;
    old = m_mode[id];
    case (m_mode[id])
      START: if (sr) begin
        m_mode[id] = GAME; m_rl[id] = rc; m_win[id] = 0;
        for (int i = 0; i < 8; i++) m_s[id][i] = 0;
      end
      GAME: begin
        first = -1; best = -1; nbest = 0; bidx = 0;
        for (int i = 0; i < np; i++) begin
          nx[i] = m_s[id][i] + int'(ev[i]);
          if (nx[i] > 15) nx[i] = 15;
          m_s[id][i] = nx[i];
          if (first < 0 && nx[i] >= ws) first = i;
          if (nx[i] > best) begin best = nx[i]; bidx = i; nbest = 1; end
          else if (nx[i] == best) nbest++;
        end
        old_rl = m_rl[id];
        if (rc > 0 && m_rl[id] > 0) m_rl[id]--;
        if (first >= 0) begin
          m_mode[id] = WIN; m_win[id] = first; m_res[id] = rs - 1;
        end else if (rc > 0 && old_rl == 1) begin
          m_res[id] = rs - 1;
          if (nbest > 1) m_mode[id] = GAME_OVER;
          else begin m_mode[id] = WIN; m_win[id] = bidx; end
        end else if (pr) m_mode[id] = PAUSE;
      end
      PAUSE: begin
        if (sr) begin
          m_mode[id] = START;
          for (int i = 0; i < 8; i++) m_s[id][i] = 0;
        end else if (pr) m_mode[id] = GAME;
      end
      default: begin
        if (sr) begin
          m_mode[id] = GAME; m_rl[id] = rc; m_win[id] = 0;
          for (int i = 0; i < 8; i++) m_s[id][i] = 0;
        end else if (m_res[id] == 0) m_mode[id] = START;
        else m_res[id]--;
      end
    endcase
    m_mc[id] = (m_mode[id] != old);
  endtask

  function automatic int pack(input int id, input int np);
    int p = 0;
    for (int i = 0; i < np; i++) p = p | (m_s[id][i] << (4 * i));
    return p;
  endfunction

  // Model steps on each active edge with the inputs the DUT saw; compare 1 time unit later.
  always begin
    @(posedge clk);
    model_step(0, 2, 3, 20, 8, rst, start_btn, pause_btn, {6'b0, evt0});
    model_step(1, 4, 15, 60, 5, rst, start_btn, pause_btn, {4'b0, evt1});
    #1;
    chk("mode0", int'(mode0), int'(m_mode[0]));
    chk("scores0", int'(scores0), pack(0, 2));
    chk("round_left0", int'(rl0), m_rl[0]);
    chk("mode_change0", int'(mc0), int'(m_mc[0]));
    if (m_mode[0] == WIN) chk("winner0", int'(winner0), m_win[0]);
    chk("mode1", int'(mode1), int'(m_mode[1]));
    chk("scores1", int'(scores1), pack(1, 4));
    chk("round_left1", int'(rl1), m_rl[1]);
    chk("mode_change1", int'(mc1), int'(m_mc[1]));
    if (m_mode[1] == WIN) chk("winner1", int'(winner1), m_win[1]);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse0(input logic [1:0] v);
    evt0 = v; cyc(1); evt0 = '0;
  endtask

  int pulses;

  initial begin
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("lit_reset_mode", int'(mode0), int'(START));
    chk("lit_reset_scores", int'(scores0), 0);
    chk("lit_reset_rl", int'(rl0), 20);
    chk("lit_reset_mc", int'(mc0), 0);

    // Held start: exactly one transition.
    start_btn = 1'b1;
    cyc(1);
    chk("lit_start_mode", int'(mode0), int'(GAME));
    chk("lit_start_mc", int'(mc0), 1);
    chk("lit_start_rl", int'(rl0), 20);
    pulses = 0;
    repeat (9) begin
      cyc(1);
      if (mc0) pulses++;
    end
    chk("lit_hold_pulses", pulses, 0);
    chk("lit_hold_rl", int'(rl0), 11);
    start_btn = 1'b0;

    // Player 1 reaches 3.
    pulse0(2'b10); cyc(1); pulse0(2'b10); cyc(1); pulse0(2'b10);
    chk("lit_win1_mode", int'(mode0), int'(WIN));
    chk("lit_win1_winner", int'(winner0), 1);
    chk("lit_win1_scores", int'(scores0), 'h30);
    cyc(7);
    chk("lit_result_hold", int'(mode0), int'(WIN));
    cyc(1);
    chk("lit_result_end", int'(mode0), int'(START));

    // Simultaneous win goes to the lowest index.
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    pulse0(2'b11); cyc(1); pulse0(2'b11); cyc(1); pulse0(2'b11);
    chk("lit_tiewin_mode", int'(mode0), int'(WIN));
    chk("lit_tiewin_winner", int'(winner0), 0);
    chk("lit_tiewin_scores", int'(scores0), 'h33);

    // Early restart from WIN, then timeout on a tie.
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    chk("lit_restart_mode", int'(mode0), int'(GAME));
    chk("lit_restart_scores", int'(scores0), 0);
    pulse0(2'b11); cyc(1); pulse0(2'b11);
    cyc(16);
    chk("lit_to_pre_rl", int'(rl0), 1);
    cyc(1);
    chk("lit_to_tie_mode", int'(mode0), int'(GAME_OVER));
    chk("lit_to_tie_rl", int'(rl0), 0);

    // Timeout with a unique leader.
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    pulse0(2'b10); pulse0(2'b11);
    cyc(18);
    chk("lit_to_win_mode", int'(mode0), int'(WIN));
    chk("lit_to_win_winner", int'(winner0), 1);
    chk("lit_to_win_rl", int'(rl0), 0);
    chk("lit_to_win_scores", int'(scores0), 'h21);

    // Pause freezes timer and scores.
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    cyc(9);
    pause_btn = 1'b1; cyc(1); pause_btn = 1'b0;
    chk("lit_pause_mode", int'(mode0), int'(PAUSE));
    chk("lit_pause_rl", int'(rl0), 10);
    repeat (50) begin
      evt0 = 2'($urandom_range(0, 3));
      cyc(1);
    end
    evt0 = '0;
    chk("lit_frozen_rl", int'(rl0), 10);
    chk("lit_frozen_scores", int'(scores0), 0);
    pause_btn = 1'b1; cyc(1);
    chk("lit_resume_mode", int'(mode0), int'(GAME));
    chk("lit_resume_rl", int'(rl0), 10);
    cyc(1);
    chk("lit_resume_count", int'(rl0), 9);
    pause_btn = 1'b0; cyc(1);

    // Reset in PAUSE and in WIN.
    pause_btn = 1'b1; cyc(1); pause_btn = 1'b0;
    chk("lit_pause2_mode", int'(mode0), int'(PAUSE));
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("lit_rstp_mode", int'(mode0), int'(START));
    chk("lit_rstp_scores", int'(scores0), 0);
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    pulse0(2'b10); cyc(1); pulse0(2'b10); cyc(1); pulse0(2'b10);
    chk("lit_win2_mode", int'(mode0), int'(WIN));
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("lit_rstw_mode", int'(mode0), int'(START));
    chk("lit_rstw_scores", int'(scores0), 0);
    chk("lit_rstw_winner", int'(winner0), 0);

    // Randomised phase, checked against the model every cycle.
    repeat (4000) begin
      rst       = ($urandom_range(0, 799) == 0);
      start_btn = ($urandom_range(0, 24) == 0) ? ~start_btn : start_btn & ($urandom_range(0, 3) != 0);
      pause_btn = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 2; i++) evt0[i] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) evt1[i] = ($urandom_range(0, 2) == 0);
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
